// File: rtl/cordic_vector_if.sv
// Start/busy/done handshake plus per-bin complex inputs and polar results
// for cordic_vector.
interface cordic_vector_if #(
  parameter int unsigned NF = 11
);
  logic                start;
  logic                busy;
  logic                done;
  logic [NF-1:0][63:0] re_i;
  logic [NF-1:0][63:0] im_i;
  logic [NF-1:0][63:0] mag_o;
  logic [NF-1:0][63:0] phase_o;

  modport master (
    output start,
    output re_i,
    output im_i,
    input  busy,
    input  done,
    input  mag_o,
    input  phase_o
  );

  modport slave (
    input  start,
    input  re_i,
    input  im_i,
    output busy,
    output done,
    output mag_o,
    output phase_o
  );
endinterface

// File: rtl/cordic_vector.sv
// Iterative CORDIC vectoring engine: converts NF complex bins (20.44 signed)
// to magnitude and atan2 phase, one bin at a time, ITER rotations per bin.
module cordic_vector #(
  parameter int unsigned NF   = 11,
  parameter int unsigned ITER = 45
) (
  input logic            clk,
  input logic            rstn,
  cordic_vector_if.slave bus
);

  localparam int unsigned KW = (NF > 1) ? $clog2(NF) : 1;

  localparam logic signed [63:0] HALF_PI = 64'sh00001_921FB54442D;
  localparam logic signed [63:0] K_GAIN  = 64'sh00000_9B74EDA8436;
  localparam logic [5:0]         I_LAST  = 6'(ITER - 1);
  localparam logic [KW-1:0]      K_LAST  = KW'(NF - 1);

  typedef logic [44:0][63:0] atan_tab_t;

  // atan(2^-n) in 20.44. Entries 0..4 are fixed constants; the rest come from
  // the Taylor series 2^-n - 2^-3n/3 + 2^-5n/5 - 2^-7n/7, which is accurate to
  // well under one LSB for n >= 5 and collapses to 2^(44-n) for n >= 15.
  function automatic atan_tab_t build_atan();
    atan_tab_t t;
    t    = '0;
    t[0] = 64'h00000_C90FDAA2217;
    t[1] = 64'h00000_76B19C1586F;
    t[2] = 64'h00000_3EB6EBF2590;
    t[3] = 64'h00000_1FD5BA9AAC3;
    t[4] = 64'h00000_0FFAADDB968;
    for (int unsigned n = 5; n < 45; n++) begin
      int          e1;
      int          e3;
      int          e5;
      int          e7;
      logic [63:0] v;
      e1 = 44 - int'(n);
      e3 = 44 - 3 * int'(n);
      e5 = 44 - 5 * int'(n);
      e7 = 44 - 7 * int'(n);
      v  = 64'd1 << e1;
      if (e3 >= 0) v = v - ((64'd1 << e3) / 64'd3);
      if (e5 >= 0) v = v + ((64'd1 << e5) / 64'd5);
      if (e7 >= 0) v = v - ((64'd1 << e7) / 64'd7);
      t[n] = v;
    end
    return t;
  endfunction

  localparam atan_tab_t ATAN = build_atan();

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    QUAD,
    CALC,
    SCALE,
    STORE,
    NEXT,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [KW-1:0]       k;
  logic [5:0]          i;
  logic signed [63:0]  x;
  logic signed [63:0]  y;
  logic signed [63:0]  z;
  logic                zero_bin;
  logic signed [63:0]  scaled;
  logic                done_r;
  logic [NF-1:0][63:0] mag_r;
  logic [NF-1:0][63:0] phase_r;

  logic signed [63:0]  atan_i;
  logic signed [63:0]  x_rot;
  logic signed [63:0]  y_rot;
  logic signed [63:0]  z_rot;
  logic signed [127:0] prod;
  logic signed [63:0]  prod_scaled;

  assign atan_i      = ATAN[i];
  assign prod        = 128'(x) * 128'(K_GAIN);
  assign prod_scaled = 64'(prod >>> 44);

  assign bus.busy    = (state != IDLE) && (state != DONE);
  assign bus.done    = done_r;
  assign bus.mag_o   = mag_r;
  assign bus.phase_o = phase_r;

  // One CORDIC micro-rotation driving y towards zero, from the current x/y/z.
  always_comb begin
    x_rot = x;
    y_rot = y;
    z_rot = z;
    if (!y[63]) begin
      x_rot = x + (y >>> i);
      y_rot = y - (x >>> i);
      z_rot = z + atan_i;
    end else begin
      x_rot = x - (y >>> i);
      y_rot = y + (x >>> i);
      z_rot = z - atan_i;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state sequencing through the per-bin pipeline of phases.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = LOAD;
      LOAD:    state_next = QUAD;
      QUAD:    state_next = CALC;
      CALC:    if (i == I_LAST) state_next = SCALE;
      SCALE:   state_next = STORE;
      STORE:   state_next = NEXT;
      NEXT:    state_next = (k == K_LAST) ? DONE : LOAD;
      DONE:    if (bus.start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand load, quadrant fold, rotations, gain scaling and
  // result write-back. done is registered, so it rises on the edge after the
  // FSM settles in DONE and drops on the edge that samples a restart.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k        <= '0;
      i        <= '0;
      x        <= '0;
      y        <= '0;
      z        <= '0;
      zero_bin <= 1'b0;
      scaled   <= '0;
      done_r   <= 1'b0;
      mag_r    <= '0;
      phase_r  <= '0;
    end else begin
      done_r <= (state == DONE) && !bus.start;
      case (state)
        LOAD: begin
          x        <= $signed(bus.re_i[k]);
          y        <= $signed(bus.im_i[k]);
          z        <= '0;
          i        <= '0;
          zero_bin <= (bus.re_i[k] == '0) && (bus.im_i[k] == '0);
        end
        QUAD: begin
          if (x[63] && !y[63]) begin
            x <= y;
            y <= -x;
            z <= HALF_PI;
          end else if (x[63] && y[63]) begin
            x <= -y;
            y <= x;
            z <= -HALF_PI;
          end
        end
        CALC: begin
          x <= x_rot;
          y <= y_rot;
          z <= z_rot;
          i <= i + 1'b1;
        end
        SCALE: scaled <= prod_scaled;
        STORE: begin
          mag_r[k]   <= zero_bin ? '0 : scaled;
          phase_r[k] <= zero_bin ? '0 : z;
        end
        NEXT: k <= (k == K_LAST) ? '0 : k + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// Directed/table-driven bench for cordic_vector at NF=11, ITER=45.
module tb_cordic_vector;

  localparam int unsigned NF   = 11;
  localparam int unsigned ITER = 45;

  localparam longint ONE       = 64'sh00001_00000000000;
  localparam longint HALF_PI   = 64'sh00001_921FB54442D;
  localparam longint PI        = 64'sh00003_243F6A8885A;
  localparam longint SQRT2     = 64'sh00001_6A09E667F3B;
  localparam longint NEG_3PI_4 = -64'sh00002_5B2F8FE6643;
  localparam longint TOL       = 256;
  localparam real    SCALE     = 17592186044416.0;
  localparam int unsigned RUN_EDGES  = NF * (ITER + 5) + 1;
  localparam int unsigned BUSY_EDGES = NF * (ITER + 5);

  logic clk = 1'b0;
  logic rstn;

  cordic_vector_if #(.NF(NF)) bus ();

  cordic_vector #(.NF(NF), .ITER(ITER)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint re;
    longint im;
    longint mag;
    longint ph;
    bit     exact;
  } vec_t;

  vec_t        tab [NF];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input longint act, input longint exp,
                       input longint tol);
    longint d;
    d = act - exp;
    if (d < 0) d = -d;
    n_total++;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %h, want %h (tol %0d)", name, act, exp, tol);
  endtask

  function automatic void model(input longint re, input longint im,
                                output longint mag, output longint ph);
    real rr;
    real ri;
    rr  = real'(re) / SCALE;
    ri  = real'(im) / SCALE;
    mag = longint'($sqrt(rr * rr + ri * ri) * SCALE);
    ph  = longint'($atan2(ri, rr) * SCALE);
  endfunction

  function automatic longint rand_val();
    return ((longint'($urandom_range(0, 1048575)) - 64'sd524288) <<< 27)
           + longint'($urandom_range(0, 65535));
  endfunction

  // Directed bins 0..6, random in-range bins 7..10, applied to the inputs.
  task automatic fill_table();
    longint m;
    longint p;
    tab[0] = '{ONE,      64'sd0,   ONE,     64'sd0,   1'b0};
    tab[1] = '{64'sd0,   ONE,      ONE,     HALF_PI,  1'b0};
    tab[2] = '{-ONE,     64'sd0,   ONE,     PI,       1'b0};
    tab[3] = '{64'sd0,   64'sd0,   64'sd0,  64'sd0,   1'b1};
    tab[4] = '{-ONE,     -ONE,     SQRT2,   NEG_3PI_4, 1'b0};
    model(3 * ONE, 4 * ONE, m, p);
    tab[5] = '{3 * ONE,  4 * ONE,  5 * ONE, p,        1'b0};
    tab[6] = '{64'sd0,   -2 * ONE, 2 * ONE, -HALF_PI, 1'b0};
    for (int unsigned k = 7; k < NF; k++) begin
      longint r;
      longint q;
      r = rand_val();
      q = rand_val();
      model(r, q, m, p);
      tab[k] = '{r, q, m, p, 1'b0};
    end
    for (int unsigned k = 0; k < NF; k++) begin
      bus.re_i[k] = tab[k].re;
      bus.im_i[k] = tab[k].im;
    end
  endtask

  task automatic check_results(input string tag);
    for (int unsigned k = 0; k < NF; k++) begin
      check($sformatf("%s_mag%0d", tag, k), longint'(bus.mag_o[k]), tab[k].mag,
            tab[k].exact ? 64'sd0 : TOL);
      check($sformatf("%s_phase%0d", tag, k), longint'(bus.phase_o[k]), tab[k].ph,
            tab[k].exact ? 64'sd0 : TOL);
    end
  endtask

  task automatic check_cleared(input string tag);
    for (int unsigned k = 0; k < NF; k++) begin
      check($sformatf("%s_mag%0d", tag, k), longint'(bus.mag_o[k]), 64'sd0, 64'sd0);
      check($sformatf("%s_phase%0d", tag, k), longint'(bus.phase_o[k]), 64'sd0, 64'sd0);
    end
  endtask

  // Start pulse, then count edges to done (bounded); optional start pulses
  // while busy must not restart the run.
  task automatic run(input string tag, input bit glitch);
    int unsigned cnt;
    bit          busy_ok;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({tag, "_busy_rise"}, longint'(bus.busy), 64'sd1, 64'sd0);
    check({tag, "_done_clear"}, longint'(bus.done), 64'sd0, 64'sd0);
    cnt     = 0;
    busy_ok = 1'b1;
    while (!bus.done && cnt < 2000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt < BUSY_EDGES && !bus.busy) busy_ok = 1'b0;
      bus.start = glitch && (cnt == 100 || cnt == 101 || cnt == 400);
    end
    bus.start = 1'b0;
    check({tag, "_done_edges"}, longint'(cnt), longint'(RUN_EDGES), 64'sd0);
    check({tag, "_busy_held"}, longint'(busy_ok), 64'sd1, 64'sd0);
    check({tag, "_busy_fall"}, longint'(bus.busy), 64'sd0, 64'sd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    rstn      = 1'b0;
    bus.start = 1'b0;
    bus.re_i  = '0;
    bus.im_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", longint'(bus.busy), 64'sd0, 64'sd0);
    check("rst_done", longint'(bus.done), 64'sd0, 64'sd0);
    check("rst_mag0", longint'(bus.mag_o[0]), 64'sd0, 64'sd0);
    check("rst_phase10", longint'(bus.phase_o[NF-1]), 64'sd0, 64'sd0);

    @(negedge clk);
    rstn = 1'b1;
    fill_table();
    repeat (4) @(posedge clk);
    #1;
    check("idle_hold_busy", longint'(bus.busy), 64'sd0, 64'sd0);

    // First run with spurious start pulses while busy.
    run("run1", 1'b1);
    check_results("run1");

    // Results and done stay put in DONE.
    repeat (20) @(posedge clk);
    #1;
    check("hold_done", longint'(bus.done), 64'sd1, 64'sd0);
    check("hold_mag5", longint'(bus.mag_o[5]), 5 * ONE, TOL);
    check("hold_phase2", longint'(bus.phase_o[2]), PI, TOL);

    // Restart from DONE, then reset during CALC of bin 5.
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("rerun_done_clear", longint'(bus.done), 64'sd0, 64'sd0);
    repeat (5 * (ITER + 5) + 20) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_busy", longint'(bus.busy), 64'sd0, 64'sd0);
    check("midrst_done", longint'(bus.done), 64'sd0, 64'sd0);
    check_cleared("midrst");
    @(negedge clk);
    rstn = 1'b1;
    fill_table();
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", longint'(bus.busy), 64'sd0, 64'sd0);

    // Fresh run after reset must produce a complete, correct result set.
    run("run2", 1'b0);
    check_results("run2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cordic_vector.md
CORDIC_VECTOR -- requirements
Module: cordic_vector

Interface
REQ-001 SHALL have parameter NF, default 11, giving the number of frequency bins processed per run.
REQ-002 SHALL have parameter ITER, default 45, range 1..45, giving the number of CORDIC vectoring iterations per bin.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: level sampled in IDLE or DONE to begin a run.
REQ-006 SHALL have port busy, output, 1 bit: high from LOAD of bin 0 through NEXT of bin NF-1.
REQ-007 SHALL have port done, output, 1 bit: high while in DONE.
REQ-008 SHALL have port re_i, input, [NF-1:0][63:0] signed 20.44: real part per bin.
REQ-009 SHALL have port im_i, input, [NF-1:0][63:0] signed 20.44: imaginary part per bin.
REQ-010 SHALL have port mag_o, output, [NF-1:0][63:0] signed 20.44: magnitude sqrt(re^2+im^2) per bin.
REQ-011 SHALL have port phase_o, output, [NF-1:0][63:0] signed 20.44: atan2(im,re) in radians per bin, range [-pi, +pi].

Function
REQ-012 SHALL implement the FSM states IDLE, LOAD, QUAD, CALC, SCALE, STORE, NEXT and DONE, with a single always-block clock domain.
REQ-013 SHALL transition IDLE->LOAD, and DONE->LOAD with done cleared, on the edge sampling start=1; otherwise it SHALL remain in the current state.
REQ-014 SHALL, in LOAD, register x=re_i[k], y=im_i[k], z=0 and i=0, where k is the bin index, 0 at run start.
REQ-015 SHALL, in QUAD, apply the following pre-rotation: if x<0 and y>=0, x'=y, y'=-x, z=+pi/2 (0x00001_921FB54442D); if x<0 and y<0, x'=-y, y'=x, z=-pi/2; otherwise hold x, y and z.
REQ-016 SHALL, in CALC, run for exactly ITER cycles, i=0..ITER-1, updating x, y and z simultaneously from their old values.
REQ-017 SHALL, in each CALC cycle with y>=0 (y[63]=0), compute x+=y>>>i, y-=x>>>i, z+=atan_i; with y<0 it SHALL compute x-=y>>>i, y+=x>>>i, z-=atan_i.
REQ-018 SHALL use atan_i = atan(2^-i) in 20.44: i=0 0x00000_C90FDAA2217, i=1 0x00000_76B19C1586F, i=2 0x00000_3EB6EBF2590, i=3 0x00000_1FD5BA9AAC3, i=4 0x00000_0FFAADDB968; for i>=15, atan_i=2^(44-i).
REQ-019 SHALL, in SCALE, compute the signed 64x64 product of x and K=0x00000_9B74EDA8436 into a 128-bit result, and keep bits [107:44], truncated.
REQ-020 SHALL, in STORE, write mag_o[k] with the scaled value and phase_o[k] with z; all other bins hold their values.
REQ-021 SHALL, when re_i[k]=im_i[k]=0, write exactly 0 to mag_o[k] and phase_o[k].
REQ-022 SHALL, in NEXT, go to LOAD with k+1 if k<NF-1; otherwise it SHALL go to DONE with k=0.
REQ-023 SHALL take 50 cycles per bin at ITER=45, i.e. ITER+5 cycles; done SHALL rise NF*(ITER+5)+1 edges after the edge sampling start.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL keep mag_o and phase_o of a completed run stable in DONE until overwritten by the next run.
REQ-026 SHALL require inputs to satisfy |re|,|im| < 2^17 (overflow-free, because CORDIC gain 1.647*sqrt2 < 2^2); outside this range results are undefined.
REQ-027 SHALL require re_i and im_i to be stable while busy=1; they are sampled only in LOAD.

Reset
REQ-028 SHALL, on rstn=0 at any time including mid-run, force the FSM to IDLE and set busy=0, done=0, k=0, i=0, x=y=z=0, mag_o=0 and phase_o=0.
REQ-029 SHALL start a new run normally on the first start=1 after rstn deasserts, with no carry-over of partial results.

Verification
REQ-030 SHALL be verified with re=0x00001_00000000000 (1.0), im=0 -> mag_o=1.0 and phase_o=0, both within ±256 LSB.
REQ-031 SHALL be verified with re=0, im=1.0 -> mag_o=1.0 and phase_o=0x00001_921FB54442D (pi/2), both within ±256 LSB.
REQ-032 SHALL be verified with re=-1.0, im=0 -> phase_o=+0x00003_243F6A8885A (+pi) and mag_o=1.0; and with re=-1.0, im=-1.0 -> mag_o=0x00001_6A09E667F3B and phase_o=-(0x00002_5B2F8FE6643), all within ±256 LSB.
REQ-033 SHALL be verified with re=im=0 in bin 3 and random in-range values elsewhere -> mag_o[3]=0 and phase_o[3]=0 exactly, and all other bins matching a double-precision model within ±256 LSB.
REQ-034 SHALL be verified for timing at NF=11, ITER=45: start pulse -> busy=1 on the next edge and done=1 exactly 551 edges after start is sampled; start=1 pulses during busy SHALL cause no restart.
REQ-035 SHALL be verified by asserting rstn=0 during CALC of bin 5 -> all outputs 0 and FSM in IDLE; a subsequent start SHALL produce the full correct result set.
